fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
Read-side controller that drains the team's synchronous FIFO in fixed-length bursts and presents each word downstream on a valid/ack handshake. It sits between the FIFO's read port (read / data_out / ready) and a consumer. It issues FIFO read strobes only when the FIFO reports data. Steady-state throughput is one word per clock.

Parameters:
BITS, 12, data word width (matches FIFO BITS)
BURST_LEN, 4, words per burst; legal range 1..2**CNT_WIDTH
CNT_WIDTH, 3, width of burst word counter; must hold BURST_LEN-1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin burst; sampled only in IDLE
abort  input  1  abandon current burst; synchronous
fifo_ready  input  1  FIFO not empty
fifo_data  input  BITS  FIFO data_out (combinational from read pointer)
fifo_read  output  1  FIFO read strobe; combinational
out_valid  output  1  out_data holds a word
out_data  output  BITS  captured word
out_last  output  1  out_valid word is last of burst
out_ack  input  1  consumer accepts word at this edge when out_valid=1
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, burst completed
word_idx  output  CNT_WIDTH  index of word currently presented

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset: state=IDLE. out_valid, out_last, busy, done, word_idx and out_data are all 0 immediately, with no clock needed. fifo_read=0 while rst=1.
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE: start=1 -> FETCH, counter=0. start is ignored in every other state.
- FETCH:
  - fifo_read = fifo_ready.
  - On an edge with fifo_ready=1: out_data<=fifo_data, out_valid<=1, -> PRESENT.
  - fifo_ready=0: remain in FETCH, busy stays 1, no timeout.
- PRESENT:
  - out_valid=1. out_data and word_idx stay stable until ack.
  - out_last = (counter==BURST_LEN-1).
  - out_ack=1 and out_last=1: out_valid<=0, -> DONE.
  - out_ack=1, out_last=0, fifo_ready=1: fifo_read=1, out_data<=fifo_data, counter+1, stay in PRESENT. This is back-to-back transfer with no bubble.
  - out_ack=1, out_last=0, fifo_ready=0: out_valid<=0, counter+1, -> FETCH.
  - out_ack=0: fifo_read=0, hold.
- DONE: done=1 for exactly one cycle, busy=1, -> IDLE. A start during DONE is ignored.
- fifo_read decode:
  - fifo_read = !rst & !abort & fifo_ready & (FETCH | (PRESENT & out_ack & !out_last)).
  - fifo_read is never asserted while fifo_ready=0, so a read is never issued against an empty FIFO.
- abort:
  - Any state -> IDLE next edge; out_valid<=0, no done pulse, counter cleared.
  - No fifo_read in the abort cycle, so undelivered words remain in the FIFO.
  - A word already captured but not acked is discarded.
- Counter: CNT_WIDTH bits; word_idx=counter. It never exceeds BURST_LEN-1, so no wrap inside a burst.
- BURST_LEN=1: the first ack goes straight to DONE, and out_last=1 whenever out_valid=1.
- Latency: the first word is on out_valid one edge after entering FETCH with fifo_ready=1, i.e. 2 cycles after start if the FIFO is non-empty.
- Reset mid-burst: the captured word is lost. Words already read from the FIFO are not restored.

Test Plan:
1. BURST_LEN=4; FIFO preloaded 0x101..0x104; pulse start; out_ack tied 1 -> fifo_read high 4 consecutive cycles starting the cycle after start; out_data 0x101,0x102,0x103,0x104 on consecutive cycles; out_last only with 0x104; done pulses 1 cycle after the final ack; FIFO ready=0 afterwards.
2. Backpressure: same preload; hold out_ack=0 for 3 cycles while 0x102 is presented -> out_data stable at 0x102, word_idx=1, fifo_read=0 for those cycles, FIFO count stays 2; burst then completes normally.
3. Underrun: FIFO holds 2 words (0x0AA, 0x0BB); start -> after 2 acks, out_valid=0, busy=1, state FETCH. Write 0x0CC, 0x0DD -> resumes; 0x0DD delivered with out_last=1; done pulses.
4. start with an empty FIFO -> busy=1, fifo_read=0 indefinitely. A second start while busy is ignored (one burst only, exactly 4 reads total).
5. abort asserted while word_idx=1 is presented -> next edge busy=0, out_valid=0, no done; the FIFO retains the 2 unread words.
6. rst asserted asynchronously mid-PRESENT (between edges) -> out_valid, busy, out_data go to 0 without a clock edge. After release, a new start runs a full burst from word_idx=0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a synchronous FIFO in fixed-length bursts and
// hands each word to a downstream consumer over a valid/ack handshake.
// Back-to-back words stream at one per clock when the FIFO keeps up.
module fifo_burst_reader #(
  parameter int BITS      = 12,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 fifo_ready,
  input  logic [BITS-1:0]      fifo_data,
  output logic                 fifo_read,
  output logic                 out_valid,
  output logic [BITS-1:0]      out_data,
  output logic                 out_last,
  input  logic                 out_ack,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] word_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BURST_LEN - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic                 at_last;

  // The counter alone decides whether the word on display closes the burst,
  // so a one-word burst is "last" from its very first word.
  assign at_last  = (counter == LAST_IDX);
  assign out_last = out_valid & at_last;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign word_idx = counter;

  // Read strobe is gated by fifo_ready so an empty FIFO is never popped, and
  // by abort so words not yet delivered stay in the FIFO.
  assign fifo_read = !rst && !abort && fifo_ready &&
                     ((state == S_FETCH) ||
                      ((state == S_PRESENT) && out_ack && !at_last));

  // Burst sequencing: fetch a word, hold it until acked, refill without a
  // bubble when the FIFO has data, fall back to FETCH when it runs dry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      counter   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      counter   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            counter <= '0;
          end
        end
        S_FETCH: begin
          if (fifo_ready) begin
            out_data  <= fifo_data;
            out_valid <= 1'b1;
            state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ack) begin
            if (at_last) begin
              out_valid <= 1'b0;
              state     <= S_DONE;
            end else if (fifo_ready) begin
              out_data <= fifo_data;
              counter  <= counter + 1'b1;
            end else begin
              out_valid <= 1'b0;
              counter   <= counter + 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          counter <= '0;
        end
        default: begin
          state     <= S_IDLE;
          counter   <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: bench with a behavioural FIFO model, a cycle table
// for the streaming burst and hand-written sequences for the corner cases.
module tb_fifo_burst_reader;

  localparam int BITS      = 12;
  localparam int BURST_LEN = 4;
  localparam int CNT_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic                 fifo_ready;
  logic [BITS-1:0]      fifo_data;
  logic                 fifo_read;
  logic                 out_valid;
  logic [BITS-1:0]      out_data;
  logic                 out_last;
  logic                 out_ack;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] word_idx;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [BITS-1:0]      data;
    logic [CNT_WIDTH-1:0] idx;
    logic                 last;
  } sb_t;

  sb_t expQ[$];

  typedef struct {
    logic                 start;
    logic                 ack;
    logic                 expRead;
    logic                 expValid;
    logic [BITS-1:0]      expData;
    logic                 expLast;
    logic                 expBusy;
    logic                 expDone;
    logic [CNT_WIDTH-1:0] expIdx;
  } vec_t;

  vec_t table1[8];

  logic [BITS-1:0] fifoMem [0:63];
  int wrPtr     = 0;
  int rdPtr     = 0;
  int readTotal = 0;

  fifo_burst_reader #(
    .BITS(BITS),
    .BURST_LEN(BURST_LEN),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .fifo_ready(fifo_ready),
    .fifo_data(fifo_data),
    .fifo_read(fifo_read),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ack(out_ack),
    .busy(busy),
    .done(done),
    .word_idx(word_idx)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  assign fifo_ready = (wrPtr != rdPtr);
  assign fifo_data  = fifoMem[rdPtr[5:0]];

  // FIFO model read side: pop one word on every strobed edge.
  always @(posedge clk) begin
    if (fifo_read) begin
      rdPtr     <= rdPtr + 1;
      readTotal <= readTotal + 1;
    end
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic ab);
    start   = s;
    out_ack = a;
    abort   = ab;
  endtask

  task automatic writeFifo(input logic [BITS-1:0] d);
    fifoMem[wrPtr[5:0]] = d;
    wrPtr = wrPtr + 1;
  endtask

  task automatic expectWord(input logic [BITS-1:0] d, input logic [CNT_WIDTH-1:0] i, input logic l);
    sb_t e;
    e.data = d;
    e.idx  = i;
    e.last = l;
    expQ.push_back(e);
  endtask

  // Let inputs settle, then score any word the consumer accepts this edge.
  task automatic settle();
    sb_t e;
    #1;
    if (out_valid && out_ack && !abort && !rst) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL sb_unexpected: got word %0h expected none", out_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_data", 32'(out_data), 32'(e.data));
        checkOutput("sb_idx", 32'(word_idx), 32'(e.idx));
        checkOutput("sb_last", 32'(out_last), 32'(e.last));
      end
    end
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  task automatic runUntilDone(input int maxCycles);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      settle();
      if (done) begin
        found = 1'b1;
        break;
      end
      advance();
    end
    checkOutput("done_pulse", 32'(found), 32'd1);
    if (found) begin
      checkOutput("done_busy", 32'(busy), 32'd1);
      checkOutput("done_valid", 32'(out_valid), 32'd0);
      checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
      advance();
      settle();
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      advance();
    end
  endtask

  task automatic runBurst();
    applyStimulus(1'b1, 1'b1, 1'b0);
    settle();
    advance();
    runUntilDone(40);
  endtask

  initial begin
    int readsBefore;

    table1[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 3'd0};
    table1[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 3'd0};
    table1[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h101, 1'b0, 1'b1, 1'b0, 3'd0};
    table1[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h102, 1'b0, 1'b1, 1'b0, 3'd1};
    table1[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h103, 1'b0, 1'b1, 1'b0, 3'd2};
    table1[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h104, 1'b1, 1'b1, 1'b0, 3'd3};
    table1[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h104, 1'b0, 1'b1, 1'b1, 3'd3};
    table1[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h104, 1'b0, 1'b0, 1'b0, 3'd0};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_idx", 32'(word_idx), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_read", 32'(fifo_read), 32'd0);
    advance();
    advance();
    rst = 1'b0;

    $display("[TB] streaming burst, ack tied high");
    for (int i = 0; i < 4; i++) begin
      writeFifo(12'h101 + 12'(i));
      expectWord(12'h101 + 12'(i), 3'(i), (i == 3));
    end
    for (int r = 0; r < 8; r++) begin
      applyStimulus(table1[r].start, table1[r].ack, 1'b0);
      settle();
      checkOutput($sformatf("t1_read_%0d", r), 32'(fifo_read), 32'(table1[r].expRead));
      checkOutput($sformatf("t1_valid_%0d", r), 32'(out_valid), 32'(table1[r].expValid));
      checkOutput($sformatf("t1_data_%0d", r), 32'(out_data), 32'(table1[r].expData));
      checkOutput($sformatf("t1_last_%0d", r), 32'(out_last), 32'(table1[r].expLast));
      checkOutput($sformatf("t1_busy_%0d", r), 32'(busy), 32'(table1[r].expBusy));
      checkOutput($sformatf("t1_done_%0d", r), 32'(done), 32'(table1[r].expDone));
      checkOutput($sformatf("t1_idx_%0d", r), 32'(word_idx), 32'(table1[r].expIdx));
      advance();
    end
    checkOutput("t1_fifo_empty", 32'(fifo_ready), 32'd0);
    checkOutput("t1_sb_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] backpressure on second word");
    for (int i = 0; i < 4; i++) begin
      writeFifo(12'h101 + 12'(i));
      expectWord(12'h101 + 12'(i), 3'(i), (i == 3));
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    settle();
    advance();
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    advance();
    settle();
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      settle();
      checkOutput("t2_data", 32'(out_data), 32'h102);
      checkOutput("t2_idx", 32'(word_idx), 32'd1);
      checkOutput("t2_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_read", 32'(fifo_read), 32'd0);
      checkOutput("t2_count", 32'(wrPtr - rdPtr), 32'd2);
      advance();
    end
    runUntilDone(20);

    $display("[TB] underrun mid-burst");
    writeFifo(12'h0AA);
    expectWord(12'h0AA, 3'd0, 1'b0);
    writeFifo(12'h0BB);
    expectWord(12'h0BB, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    settle();
    advance();
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    advance();
    settle();
    advance();
    settle();
    checkOutput("t3_last_read", 32'(fifo_read), 32'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("t3_valid", 32'(out_valid), 32'd0);
      checkOutput("t3_busy", 32'(busy), 32'd1);
      checkOutput("t3_read", 32'(fifo_read), 32'd0);
      checkOutput("t3_idx", 32'(word_idx), 32'd2);
      advance();
    end
    writeFifo(12'h0CC);
    expectWord(12'h0CC, 3'd2, 1'b0);
    writeFifo(12'h0DD);
    expectWord(12'h0DD, 3'd3, 1'b1);
    runUntilDone(20);

    $display("[TB] start against empty FIFO, second start ignored");
    readsBefore = readTotal;
    applyStimulus(1'b1, 1'b1, 1'b0);
    settle();
    advance();
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 2), 1'b1, 1'b0);
      settle();
      checkOutput("t4_busy", 32'(busy), 32'd1);
      checkOutput("t4_read", 32'(fifo_read), 32'd0);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      writeFifo(12'h401 + 12'(i));
      expectWord(12'h401 + 12'(i), 3'(i), (i == 3));
    end
    runUntilDone(20);
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("t4_idle", 32'(busy), 32'd0);
      advance();
    end
    checkOutput("t4_reads", 32'(readTotal - readsBefore), 32'd4);

    $display("[TB] abort while second word presented");
    for (int i = 0; i < 4; i++) writeFifo(12'h201 + 12'(i));
    expectWord(12'h201, 3'd0, 1'b0);
    expectWord(12'h202, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    settle();
    advance();
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    advance();
    settle();
    advance();
    applyStimulus(1'b0, 1'b1, 1'b1);
    settle();
    checkOutput("t5_abort_read", 32'(fifo_read), 32'd0);
    checkOutput("t5_abort_data", 32'(out_data), 32'h202);
    checkOutput("t5_abort_idx", 32'(word_idx), 32'd1);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_idx", 32'(word_idx), 32'd0);
    checkOutput("t5_count", 32'(wrPtr - rdPtr), 32'd2);
    advance();
    settle();
    checkOutput("t5_no_done", 32'(done), 32'd0);
    checkOutput("t5_discarded", 32'(expQ.size()), 32'd1);
    expQ.delete();
    advance();
    expectWord(12'h203, 3'd0, 1'b0);
    expectWord(12'h204, 3'd1, 1'b0);
    writeFifo(12'h205);
    expectWord(12'h205, 3'd2, 1'b0);
    writeFifo(12'h206);
    expectWord(12'h206, 3'd3, 1'b1);
    runBurst();

    $display("[TB] async reset mid-present");
    for (int i = 0; i < 4; i++) writeFifo(12'h301 + 12'(i));
    expectWord(12'h301, 3'd0, 1'b0);
    expectWord(12'h302, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    settle();
    advance();
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    advance();
    settle();
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("t6_pre_data", 32'(out_data), 32'h302);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_data", 32'(out_data), 32'd0);
    checkOutput("t6_idx", 32'(word_idx), 32'd0);
    checkOutput("t6_read", 32'(fifo_read), 32'd0);
    advance();
    rst = 1'b0;
    checkOutput("t6_lost", 32'(expQ.size()), 32'd1);
    expQ.delete();
    expectWord(12'h303, 3'd0, 1'b0);
    expectWord(12'h304, 3'd1, 1'b0);
    writeFifo(12'h305);
    expectWord(12'h305, 3'd2, 1'b0);
    writeFifo(12'h306);
    expectWord(12'h306, 3'd3, 1'b1);
    runBurst();
    checkOutput("final_fifo_empty", 32'(wrPtr - rdPtr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
